bit_nibble_packer: RTL and testbench

Serial-to-nibble packer that sits directly upstream of the bitwise-operation stage and feeds its 4-bit ascending-range input bus. It accepts one bit per cycle under a valid/ready handshake and packs four consecutive bits into a `[0:3]` nibble, with the first received bit at index 0. It presents the nibble through a one-entry output register with valid/ready backpressure. A flush pulse pads and emits a partially filled nibble, and a wrapping counter tracks emitted nibbles.

---
 rtl/bit_nibble_packer.sv | 101 ++++++++++
 tb/tb_bit_nibble_packer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/bit_nibble_packer.sv
// rtl/bit_nibble_packer.sv - serial bit to [0:3] nibble packer with flush padding and output register
module bit_nibble_packer #(
  parameter logic PAD_BIT = 1'b0,
  parameter int   CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             flush,
  output logic [0:3]       nibble,
  output logic             nibble_valid,
  input  logic             nibble_ready,
  output logic             nibble_partial,
  output logic [CNT_W-1:0] nibble_cnt
);

  typedef enum logic {S_FILL, S_FLUSH_PEND} state_t;

  state_t     state, state_nxt;
  logic [1:0] fill, fill_after, fill_nxt;
  logic [0:3] asm_q, asm_nxt, merged, padded, load_data;
  logic       slot_free, accept, load, load_partial;

  always_comb begin
    slot_free    = !nibble_valid || nibble_ready;
    bit_ready    = (state == S_FILL) && ((fill != 2'd3) || slot_free);
    accept       = bit_valid && bit_ready;
    merged       = asm_q;
    if (accept) merged[fill] = bit_in;
    // fill wraps 3 -> 0 exactly when a nibble completes
    fill_after   = fill + {1'b0, accept};
    padded       = merged;
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(fill_after)) padded[i] = PAD_BIT;
    end

    state_nxt    = state;
    fill_nxt     = fill_after;
    asm_nxt      = merged;
    load         = 1'b0;
    load_data    = nibble;
    load_partial = nibble_partial;

    case (state)
      S_FILL: begin
        if (accept && (fill == 2'd3)) begin
          load         = 1'b1;
          load_data    = merged;
          load_partial = 1'b0;
        end else if (flush && (fill_after != 2'd0)) begin
          if (slot_free) begin
            load         = 1'b1;
            load_data    = padded;
            load_partial = 1'b1;
            fill_nxt     = 2'd0;
          end else begin
            state_nxt = S_FLUSH_PEND;
            asm_nxt   = padded;
          end
        end
      end
      S_FLUSH_PEND: begin
        if (slot_free) begin
          load         = 1'b1;
          load_data    = asm_q;
          load_partial = 1'b1;
          fill_nxt     = 2'd0;
          state_nxt    = S_FILL;
        end
      end
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_FILL;
      fill           <= 2'd0;
      asm_q          <= 4'b0;
      nibble         <= 4'b0;
      nibble_valid   <= 1'b0;
      nibble_partial <= 1'b0;
      nibble_cnt     <= '0;
    end else begin
      state <= state_nxt;
      fill  <= fill_nxt;
      asm_q <= asm_nxt;
      if (load) begin
        nibble         <= load_data;
        nibble_partial <= load_partial;
        nibble_valid   <= 1'b1;
      end else if (nibble_ready) begin
        nibble_valid <= 1'b0;
      end
      if (nibble_valid && nibble_ready) nibble_cnt <= nibble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bit_nibble_packer.sv
// tb/tb_bit_nibble_packer.sv - scoreboard bench for bit_nibble_packer
module tb_bit_nibble_packer;
  localparam logic PAD = 1'b0;
  localparam int   CW  = 2;

  logic          clk = 0, rst_n = 0;
  logic          bit_in = 0, bit_valid = 0, flush = 0, nibble_ready = 0;
  logic          bit_ready, nibble_valid, nibble_partial;
  logic [0:3]    nibble;
  logic [CW-1:0] nibble_cnt;

  int errors = 0, checks = 0;

  typedef struct { logic [0:3] n; logic p; } exp_t;
  exp_t exp_q[$];
  bit   cur[$];
  bit   pend;
  logic [CW-1:0] cnt_exp;

  bit_nibble_packer #(.PAD_BIT(PAD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .flush(flush), .nibble(nibble),
    .nibble_valid(nibble_valid), .nibble_ready(nibble_ready),
    .nibble_partial(nibble_partial), .nibble_cnt(nibble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model: bits collected in a list, a nibble is expected whenever
  // four bits arrive or a flush finds a non-empty list.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur.delete();
      exp_q.delete();
      pend = 0;
    end else begin
      bit   slot_free, exp_rdy;
      exp_t e;
      slot_free = !nibble_valid || nibble_ready;
      exp_rdy   = !pend && (cur.size() < 3 || slot_free);
      chk("bit_ready", int'(bit_ready), int'(exp_rdy));
      if (pend) begin
        if (slot_free) pend = 0;
      end else begin
        if (bit_valid && exp_rdy) begin
          cur.push_back(bit_in);
          if (cur.size() == 4) begin
            for (int i = 0; i < 4; i++) e.n[i] = cur[i];
            e.p = 1'b0;
            exp_q.push_back(e);
            cur.delete();
          end
        end
        if (flush && cur.size() > 0) begin
          for (int i = 0; i < 4; i++) e.n[i] = (i < cur.size()) ? cur[i] : PAD;
          e.p = 1'b1;
          exp_q.push_back(e);
          cur.delete();
          if (!slot_free) pend = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      cnt_exp = '0;
    end else begin
      exp_t e;
      chk("nibble_cnt", int'(nibble_cnt), int'(cnt_exp));
      if (nibble_valid && nibble_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_nibble", int'(nibble), -1);
        end else begin
          e = exp_q.pop_front();
          chk("nibble", int'(nibble), int'(e.n));
          chk("nibble_partial", int'(nibble_partial), int'(e.p));
        end
        cnt_exp = cnt_exp + 1'b1;
      end
    end
  end

  task automatic step(input logic v, input logic b, input logic f, input logic r);
    @(posedge clk); #1;
    bit_valid = v; bit_in = b; flush = f; nibble_ready = r;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_nibble"}, int'(nibble), 0);
    chk({tag, "_valid"}, int'(nibble_valid), 0);
    chk({tag, "_partial"}, int'(nibble_partial), 0);
    chk({tag, "_cnt"}, int'(nibble_cnt), 0);
    chk({tag, "_bit_ready"}, int'(bit_ready), 1);
  endtask

  initial begin
    logic [0:3] pat;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1;

    pat = 4'b1011;
    for (int i = 0; i < 4; i++) step(1, pat[i], 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    for (int i = 0; i < 12; i++) step(1, 1'($urandom), 0, 1);
    step(0, 0, 0, 1);

    // stall: first nibble held while four more bits arrive
    for (int i = 0; i < 4; i++) step(1, 1'($urandom), 0, i == 0);
    for (int i = 0; i < 4; i++) step(1, 1'($urandom), 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    step(1, 1, 0, 1); step(1, 1, 0, 1); step(0, 0, 1, 1);
    step(0, 0, 0, 1); step(0, 0, 1, 1); step(0, 0, 0, 1);

    // flush while output stalled
    for (int i = 0; i < 4; i++) step(1, 1'($urandom), 0, 0);
    step(1, 1, 0, 0); step(0, 0, 1, 0);
    step(1, 0, 1, 0); step(1, 1, 0, 0); step(1, 1, 0, 1);
    step(0, 0, 0, 1); step(0, 0, 0, 1);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 8, 1'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 7);

    // reset with a partial nibble in flight
    step(0, 0, 0, 1); step(0, 0, 0, 1);
    step(1, 1, 0, 1); step(1, 1, 0, 1);
    @(posedge clk); #1;
    bit_valid = 0; rst_n = 0; #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1;
    pat = 4'b0110;
    for (int i = 0; i < 4; i++) step(1, pat[i], 0, 1);

    for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
